// File: rtl/l3_resp_tx_pkg.sv
// ---------------------------------------------------------------------------
// l3_resp_tx_pkg
// Shared definitions for the SPI layer-3 response path: the serial byte
// width, the default filler byte sent when no response is queued, and the
// serializer state encoding.
// ---------------------------------------------------------------------------
package l3_resp_tx_pkg;

    localparam int SPI_BYTE_W = 8;

    localparam logic [SPI_BYTE_W-1:0] IDLE_BYTE_DEF = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_t;

endpackage

// File: rtl/l3_resp_fifo.sv
// ---------------------------------------------------------------------------
// l3_resp_fifo
// Synchronous first-word-fall-through byte FIFO with flush and a registered
// occupancy count. Besides the head entry it also exposes the entry behind
// the head, so a consumer that pops can reload in the same edge.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         empties the FIFO at the next edge (wins over push/pop)
//   push          write push_data (ignored when full and not popping)
//   push_data     byte to enqueue
//   pop           discard the head entry (ignored when empty)
//   head_data     current head entry (valid when !empty)
//   second_data   entry behind the head (valid when level >= 2)
//   level         number of bytes queued
//   full, empty   occupancy flags derived from level
// ---------------------------------------------------------------------------
module l3_resp_fifo
    import l3_resp_tx_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [SPI_BYTE_W-1:0] push_data,
    input  logic                  pop,
    output logic [SPI_BYTE_W-1:0] head_data,
    output logic [SPI_BYTE_W-1:0] second_data,
    output logic [LVL_W-1:0]      level,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [SPI_BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    // A push into a full FIFO is fine as long as the head leaves in the
    // same edge: the write slot is then the slot being vacated.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign head_data   = mem[rd_ptr];
    assign second_data = mem[rd_ptr + PTR_W'(1)];

    // Storage array; no reset needed because level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/l3_resp_tx.sv
// ---------------------------------------------------------------------------
// l3_resp_tx
// Buffers layer-3 response bytes and serializes them MSB-first onto the SPI
// slave MISO line (mode 0). CS and SCK arrive already synchronized into the
// clk domain: cs_active is a level, sck_shift a one-clk strobe per falling
// SCK edge. When nothing is queued the filler byte IDLE_BYTE is sent.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr_core       synchronous flush of all queued responses
//   core_resp      response byte from the L3 response stage
//   core_resp_vld  core_resp valid; transfer on core_resp_vld & resp_rdy
//   resp_rdy       FIFO can accept a byte this cycle
//   cs_active      synchronized chip select, active high
//   sck_shift      shift strobe (SCK falling edge)
//   miso           serial data out, MSB first
//   miso_oe        MISO output enable
//   fifo_level     number of bytes queued
//   tx_done        one-clk pulse when a byte completes 8 shifts
//   tx_abort       one-clk pulse when CS drops in the middle of a byte
// ---------------------------------------------------------------------------
module l3_resp_tx
    import l3_resp_tx_pkg::*;
#(
    parameter int                    DEPTH     = 4,
    parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF,
    parameter int                    LVL_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_core,
    input  logic [SPI_BYTE_W-1:0] core_resp,
    input  logic                  core_resp_vld,
    output logic                  resp_rdy,
    input  logic                  cs_active,
    input  logic                  sck_shift,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  tx_done,
    output logic                  tx_abort
);

    localparam logic [2:0] LAST_BIT = 3'(SPI_BYTE_W - 1);

    tx_state_t             state;
    logic [SPI_BYTE_W-1:0] shreg;
    logic [2:0]            bit_cnt;
    logic                  byte_valid;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [SPI_BYTE_W-1:0] fifo_head;
    logic [SPI_BYTE_W-1:0] fifo_second;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  byte_end;
    logic [SPI_BYTE_W-1:0] load_byte;
    logic                  load_valid;

    // A byte completes on the eighth shift strobe while CS is still held;
    // a CS drop in the same cycle wins and the byte is not consumed.
    assign byte_end = (state == ST_SHIFT) && cs_active && sck_shift
                      && (bit_cnt == LAST_BIT);
    assign fifo_pop = byte_end && byte_valid && !clr_core;

    // Accept a new byte when there is room, including the slot freed by a
    // pop in this same edge, but never while a flush is in progress.
    assign resp_rdy  = (!fifo_full || fifo_pop) && !clr_core;
    assign fifo_push = core_resp_vld && resp_rdy;

    l3_resp_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (clr_core),
        .push        (fifo_push),
        .push_data   (core_resp),
        .pop         (fifo_pop),
        .head_data   (fifo_head),
        .second_data (fifo_second),
        .level       (fifo_level),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // Select the byte the serializer loads next. Loads see the queue as it
    // stands before this edge's push; after a pop that means the entry behind
    // the head. A flush makes the queue count as empty, so the filler goes
    // out instead of stale data.
    always_comb begin
        load_byte  = IDLE_BYTE;
        load_valid = 1'b0;
        if (fifo_pop) begin
            if (fifo_level > LVL_W'(1)) begin
                load_byte  = fifo_second;
                load_valid = 1'b1;
            end
        end else if (!fifo_empty && !clr_core) begin
            load_byte  = fifo_head;
            load_valid = 1'b1;
        end
    end

    // Serializer FSM. miso/miso_oe are registered and always track the MSB
    // of the shift register value being written in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shreg      <= IDLE_BYTE;
            bit_cnt    <= '0;
            byte_valid <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            tx_done    <= 1'b0;
            tx_abort   <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            case (state)
                ST_IDLE: begin
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                    if (cs_active) begin
                        shreg      <= load_byte;
                        byte_valid <= load_valid;
                        bit_cnt    <= '0;
                        miso       <= load_byte[SPI_BYTE_W-1];
                        miso_oe    <= 1'b1;
                        state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (!cs_active) begin
                        // Aborted byte stays queued for the next frame.
                        tx_abort <= (bit_cnt != '0);
                        bit_cnt  <= '0;
                        miso     <= 1'b0;
                        miso_oe  <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (sck_shift) begin
                        if (bit_cnt == LAST_BIT) begin
                            tx_done    <= 1'b1;
                            shreg      <= load_byte;
                            byte_valid <= load_valid;
                            bit_cnt    <= '0;
                            miso       <= load_byte[SPI_BYTE_W-1];
                        end else begin
                            shreg   <= {shreg[SPI_BYTE_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                            miso    <= shreg[SPI_BYTE_W-2];
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // A flush keeps the bits in flight but the byte no longer owns a
            // FIFO entry, so its completion must not pop.
            if (clr_core) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule
